// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : ALU select codes, alu_op constants and FSM/latency enums.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [4:0] SEL_AND  = 5'b00000;
  localparam logic [4:0] SEL_OR   = 5'b00001;
  localparam logic [4:0] SEL_ADD  = 5'b00010;
  localparam logic [4:0] SEL_XOR  = 5'b00011;
  localparam logic [4:0] SEL_SLL  = 5'b00100;
  localparam logic [4:0] SEL_SRL  = 5'b00101;
  localparam logic [4:0] SEL_SUB  = 5'b00110;
  localparam logic [4:0] SEL_SRA  = 5'b00111;
  localparam logic [4:0] SEL_SLT  = 5'b01000;
  localparam logic [4:0] SEL_SLTU = 5'b01001;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_R   = 2'd2;
  localparam logic [1:0] ALU_I   = 2'd3;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef enum logic [1:0] {
    LAT_ONE = 2'd0,
    LAT_MUL = 2'd1,
    LAT_DIV = 2'd2
  } lat_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Base funct3 operation, shared by R-type (func7=0) and I-type decode.
  function automatic logic [4:0] f3_sel(input logic [2:0] f3);
    logic [4:0] s;
    case (f3)
      3'd0:    s = SEL_ADD;
      3'd1:    s = SEL_SLL;
      3'd2:    s = SEL_SLT;
      3'd3:    s = SEL_SLTU;
      3'd4:    s = SEL_XOR;
      3'd5:    s = SEL_SRL;
      3'd6:    s = SEL_OR;
      default: s = SEL_AND;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sel_decode.sv
// ============================================================================
// Module      : alu_sel_decode
// Description : Combinational alu_op/func3/func7 to ALU/MDU select decode.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_sel_decode
  import alu_pkg::*;
#(
  parameter int SEL_W    = 5,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [1:0]       alu_op,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  output logic [SEL_W-1:0] sel,
  output logic             is_m,
  output lat_sel_e         lat_sel,
  output logic             illegal
);

  logic [4:0] w_code;
  logic       w_ill;
  logic       w_m;
  lat_sel_e   w_lat;

  always_comb begin
    w_code = SEL_ADD;
    w_ill  = 1'b0;
    w_m    = 1'b0;
    w_lat  = LAT_ONE;
    case (alu_op)
      ALU_ADD: w_code = SEL_ADD;
      ALU_SUB: w_code = SEL_SUB;
      ALU_R: begin
        if (func7 == F7_BASE) begin
          w_code = f3_sel(func3);
        end else if (func7 == F7_ALT) begin
          if (func3 == 3'd0)      w_code = SEL_SUB;
          else if (func3 == 3'd5) w_code = SEL_SRA;
          else                    w_ill  = 1'b1;
        end else if (func7 == F7_MULDIV && ENABLE_M) begin
          w_code = {2'b10, func3};
          w_m    = 1'b1;
          w_lat  = func3[2] ? LAT_DIV : LAT_MUL;
        end else begin
          w_ill = 1'b1;
        end
      end
      default: begin
        // I-type: only the shift encodings constrain imm[11:5].
        if (func3 == 3'd1) begin
          if (func7 == F7_BASE) w_code = SEL_SLL;
          else                  w_ill  = 1'b1;
        end else if (func3 == 3'd5) begin
          if (func7 == F7_BASE)     w_code = SEL_SRL;
          else if (func7 == F7_ALT) w_code = SEL_SRA;
          else                      w_ill  = 1'b1;
        end else begin
          w_code = f3_sel(func3);
        end
      end
    endcase
    if (w_ill) begin
      w_code = SEL_ADD;
      w_m    = 1'b0;
      w_lat  = LAT_ONE;
    end
  end

  assign sel     = SEL_W'(w_code);
  assign is_m    = w_m;
  assign lat_sel = w_lat;
  assign illegal = w_ill;

endmodule

`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
// ============================================================================
// Module      : alu_ctrl_seq
// Description : Registered, handshaked ALU control with multi-cycle M sequencing.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int SEL_W      = 5,
  parameter bit ENABLE_M   = 1'b1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic             multicycle,
  output logic             busy,
  output logic             illegal
);

  localparam logic [5:0] c_mul_lat = 6'(MUL_CYCLES);
  localparam logic [5:0] c_div_lat = 6'(DIV_CYCLES);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [5:0]       r_cnt;
  logic [5:0]       r_last;
  logic [SEL_W-1:0] r_sel;
  logic             r_mc;
  logic             r_ill;

  logic [SEL_W-1:0] w_dec_sel;
  logic             w_dec_m;
  logic             w_dec_ill;
  lat_sel_e         w_dec_lat;
  logic [5:0]       w_lat;
  logic             w_long;
  logic             w_accept;

  alu_sel_decode #(
    .SEL_W    (SEL_W),
    .ENABLE_M (ENABLE_M)
  ) u_dec (
    .alu_op  (alu_op),
    .func3   (func3),
    .func7   (func7),
    .sel     (w_dec_sel),
    .is_m    (w_dec_m),
    .lat_sel (w_dec_lat),
    .illegal (w_dec_ill)
  );

  assign out_valid  = (r_state == ST_DONE);
  assign busy       = (r_state == ST_COUNT);
  assign in_ready   = !busy && (!out_valid || out_ready);
  assign w_accept   = in_valid && in_ready && !flush;
  assign sel        = r_sel;
  assign multicycle = r_mc;
  assign illegal    = r_ill;

  always_comb begin
    w_lat = 6'd1;
    case (w_dec_lat)
      LAT_MUL: w_lat = c_mul_lat;
      LAT_DIV: w_lat = c_div_lat;
      default: w_lat = 6'd1;
    endcase
  end

  assign w_long = (w_lat > 6'd1);

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) w_state_nxt = w_long ? ST_COUNT : ST_DONE;
        end
        ST_COUNT: begin
          if (r_cnt == r_last) w_state_nxt = ST_DONE;
        end
        ST_DONE: begin
          if (w_accept)       w_state_nxt = w_long ? ST_COUNT : ST_DONE;
          else if (out_ready) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // r_last is L-2: the count seen in the final busy cycle, so DONE lands at edge N+L-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 6'd0;
      r_last <= 6'd0;
    end else if (flush) begin
      r_cnt  <= 6'd0;
    end else if (w_accept) begin
      r_cnt  <= 6'd0;
      r_last <= w_lat - 6'd2;
    end else if (busy && r_cnt != 6'd63) begin
      r_cnt  <= r_cnt + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= '0;
      r_mc  <= 1'b0;
      r_ill <= 1'b0;
    end else if (w_accept) begin
      r_sel <= w_dec_sel;
      r_mc  <= w_dec_m;
      r_ill <= w_dec_ill;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
// ============================================================================
// Module      : tb_alu_ctrl_seq
// Description : Directed self-checking bench for alu_ctrl_seq.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] alu_op = 2'd0;
  logic [2:0] func3 = 3'd0;
  logic [6:0] func7 = 7'd0;

  logic       in_ready, out_valid, multicycle, busy, illegal;
  logic [4:0] sel;
  logic       nm_in_ready, nm_out_valid, nm_multicycle, nm_busy, nm_illegal;
  logic [4:0] nm_sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.SEL_W(5), .ENABLE_M(1'b1), .MUL_CYCLES(8), .DIV_CYCLES(33)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .func3(func3), .func7(func7), .out_valid(out_valid),
    .out_ready(out_ready), .sel(sel), .multicycle(multicycle), .busy(busy),
    .illegal(illegal)
  );

  alu_ctrl_seq #(.SEL_W(5), .ENABLE_M(1'b0), .MUL_CYCLES(2), .DIV_CYCLES(33)) dut_nm (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
    .alu_op(alu_op), .func3(func3), .func7(func7), .out_valid(nm_out_valid),
    .out_ready(out_ready), .sel(nm_sel), .multicycle(nm_multicycle), .busy(nm_busy),
    .illegal(nm_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode written straight from the encoding table.
  function automatic void ref_dec(input int a, input int f3, input int f7, input bit en_m,
                                  output logic [4:0] s, output bit ill, output bit m);
    logic [4:0] tab [0:7];
    tab[0] = 5'b00010; tab[1] = 5'b00100; tab[2] = 5'b01000; tab[3] = 5'b01001;
    tab[4] = 5'b00011; tab[5] = 5'b00101; tab[6] = 5'b00001; tab[7] = 5'b00000;
    s = 5'b00010; ill = 1'b0; m = 1'b0;
    if (a == 1) s = 5'b00110;
    else if (a == 2) begin
      if (f7 == 'h00)                  s = tab[f3];
      else if (f7 == 'h20 && f3 == 0)  s = 5'b00110;
      else if (f7 == 'h20 && f3 == 5)  s = 5'b00111;
      else if (f7 == 'h01 && en_m) begin s = 5'(16 + f3); m = 1'b1; end
      else                             ill = 1'b1;
    end else if (a == 3) begin
      if (f3 == 1 && f7 != 0)              ill = 1'b1;
      else if (f3 == 5 && f7 == 'h20)      s = 5'b00111;
      else if (f3 == 5 && f7 != 0)         ill = 1'b1;
      else                                 s = tab[f3];
    end
    if (ill) s = 5'b00010;
  endfunction

  int         f7s [0:3];
  logic [4:0] es;
  bit         ei, em;
  int         w;
  logic [1:0] s_op  [0:3];
  logic [2:0] s_f3  [0:3];
  logic [6:0] s_f7  [0:3];
  int         s_idx [0:6];
  logic       s_ordy[0:6];
  logic       s_ov  [0:6];
  logic       s_ir  [0:6];
  logic [4:0] s_sel [0:6];

  initial begin
    f7s[0] = 'h00; f7s[1] = 'h20; f7s[2] = 'h01; f7s[3] = 'h7F;

    // ---------------- async reset mid-cycle ----------------
    #3 rst = 1'b1;
    #1;
    check("rst_sel", sel, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_multicycle", multicycle, 0);
    check("rst_illegal", illegal, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("rel_in_ready", in_ready, 1);
    alu_op = 2'd2; func3 = 3'd0; func7 = 7'h20; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("sub_out_valid", out_valid, 1);
    check("sub_sel", sel, 5'b00110);
    check("sub_illegal", illegal, 0);
    out_ready = 1'b1;

    // ---------------- decode sweep, both ENABLE_M settings ----------------
    for (int a = 0; a < 4; a++) begin
      for (int f3 = 0; f3 < 8; f3++) begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          alu_op = 2'(a); func3 = 3'(f3); func7 = 7'(f7s[k]);
          in_valid = 1'b1; out_ready = 1'b1;
          @(negedge clk);
          in_valid = 1'b0;
          ref_dec(a, f3, f7s[k], 1'b0, es, ei, em);
          check("nm_out_valid", nm_out_valid, 1);
          check("nm_sel", nm_sel, es);
          check("nm_illegal", nm_illegal, ei);
          check("nm_multicycle", nm_multicycle, em);
          ref_dec(a, f3, f7s[k], 1'b1, es, ei, em);
          w = 0;
          while (!out_valid && w < 40) begin @(negedge clk); w++; end
          check("m_out_valid", out_valid, 1);
          check("m_sel", sel, es);
          check("m_illegal", illegal, ei);
          check("m_multicycle", multicycle, em);
        end
      end
    end

    // ---------------- DIV, 33 cycles ----------------
    @(negedge clk); @(negedge clk);
    alu_op = 2'd2; func3 = 3'd4; func7 = 7'h01; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 32; c++) begin
      check("div_busy", busy, 1);
      check("div_in_ready", in_ready, 0);
      check("div_out_valid", out_valid, 0);
      check("div_sel", sel, 5'b10100);
      @(negedge clk);
    end
    check("div_done_valid", out_valid, 1);
    check("div_done_busy", busy, 0);
    check("div_done_sel", sel, 5'b10100);
    check("div_multicycle", multicycle, 1);
    @(negedge clk);
    check("div_idle", out_valid, 0);

    // ---------------- stream of 4 single-cycle ops ----------------
    s_op[0] = 2'd3; s_f3[0] = 3'd4; s_f7[0] = 7'h00;  // XOR  00011
    s_op[1] = 2'd2; s_f3[1] = 3'd6; s_f7[1] = 7'h00;  // OR   00001
    s_op[2] = 2'd1; s_f3[2] = 3'd0; s_f7[2] = 7'h00;  // SUB  00110
    s_op[3] = 2'd3; s_f3[3] = 3'd3; s_f7[3] = 7'h7F;  // SLTU 01001
    s_idx[0]=0;  s_ordy[0]=1; s_ov[0]=0; s_ir[0]=1; s_sel[0]=5'b10100;
    s_idx[1]=1;  s_ordy[1]=0; s_ov[1]=1; s_ir[1]=0; s_sel[1]=5'b00011;
    s_idx[2]=1;  s_ordy[2]=1; s_ov[2]=1; s_ir[2]=1; s_sel[2]=5'b00011;
    s_idx[3]=2;  s_ordy[3]=1; s_ov[3]=1; s_ir[3]=1; s_sel[3]=5'b00001;
    s_idx[4]=3;  s_ordy[4]=1; s_ov[4]=1; s_ir[4]=1; s_sel[4]=5'b00110;
    s_idx[5]=-1; s_ordy[5]=1; s_ov[5]=1; s_ir[5]=1; s_sel[5]=5'b01001;
    s_idx[6]=-1; s_ordy[6]=1; s_ov[6]=0; s_ir[6]=1; s_sel[6]=5'b01001;
    for (int c = 0; c < 7; c++) begin
      out_ready = s_ordy[c];
      if (s_idx[c] >= 0) begin
        in_valid = 1'b1;
        alu_op = s_op[s_idx[c]]; func3 = s_f3[s_idx[c]]; func7 = s_f7[s_idx[c]];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("str_out_valid", out_valid, s_ov[c]);
      check("str_in_ready", in_ready, s_ir[c]);
      check("str_sel", sel, s_sel[c]);
      @(negedge clk);
    end

    // ---------------- flush during MUL (8 cycles) ----------------
    alu_op = 2'd2; func3 = 3'd0; func7 = 7'h01; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("mul_busy", busy, 1);
      check("mul_out_valid", out_valid, 0);
      @(negedge clk);
    end
    flush = 1'b1; alu_op = 2'd0; func3 = 3'd0; func7 = 7'h00; in_valid = 1'b1;
    @(negedge clk);
    check("fl_busy", busy, 0);
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_sel_held", sel, 5'b10000);
    alu_op = 2'd1;  // flush still high while IDLE: must not accept
    @(negedge clk);
    check("fl_idle_valid", out_valid, 0);
    check("fl_idle_sel", sel, 5'b10000);
    flush = 1'b0; alu_op = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    check("re_add_valid", out_valid, 1);
    check("re_add_sel", sel, 5'b00010);
    check("re_add_mc", multicycle, 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, handshaked ALU control unit for the RV32IC core. It decodes ALUOp/func3/func7 into a SEL_W-bit ALU select covering full RV32I arithmetic, plus optional RV32M. It sequences multi-cycle M-extension operations by holding the select stable and stalling issue until the iterative unit's latency has elapsed. It sits between the decode stage and the execute-stage ALU/MDU operand path.

## Interface
- SEL_W, 5, select width; must be ≥5.
- ENABLE_M, 1, 1 = decode RV32M; 0 = M encodings flagged illegal.
- MUL_CYCLES, 2, MUL* latency in cycles, range 1..15.
- DIV_CYCLES, 33, DIV*/REM* latency in cycles, range 1..63.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous, active-high reset.
- flush, in, 1, kills the held and in-flight op.
- in_valid, in, 1, a decoded op is presented.
- in_ready, out, 1, the op is accepted this cycle.
- alu_op, in, 2, 0 = ADD (ld/st/auipc), 1 = SUB (branch), 2 = R-type, 3 = I-type ALU.
- func3, in, 3, instruction funct3.
- func7, in, 7, instruction funct7 (I-type: imm[11:5]).
- out_valid, out, 1, sel is final and the result is ready.
- out_ready, in, 1, the consumer takes the result.
- sel, out, SEL_W, ALU/MDU select.
- multicycle, out, 1, the held op is an M op.
- busy, out, 1, the latency counter is running.
- illegal, out, 1, the held op had an unsupported encoding.

## Operation
- sel codes: ADD=00010, SUB=00110, AND=00000, OR=00001, XOR=00011, SLL=00100, SRL=00101, SRA=00111, SLT=01000, SLTU=01001, M op = {1'b1, func3} (MUL=10000 … REMU=10111). Codes are zero-extended to SEL_W.
- alu_op 0 → ADD. alu_op 1 → SUB.
- alu_op 2, func7=0x00 → the funct3 op (0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND).
- alu_op 2, func7=0x20 → func3 0 gives SUB, func3 5 gives SRA; any other func3 is illegal.
- alu_op 2, func7=0x01 → M op if ENABLE_M; otherwise illegal.
- alu_op 2, any other func7 → illegal.
- alu_op 3: same funct3 map, never SUB. func3 1 requires func7=0. func3 5 requires func7 ∈ {0x00, 0x20} (0x20 gives SRA). Other func7 values on these two func3 are illegal; all other func3 ignore func7.
- An illegal op forces sel=ADD, illegal=1, and is treated as single-cycle.
- Accept = in_valid & in_ready & !flush.
- in_ready = !busy & (!out_valid | out_ready).
- FSM states:
  - IDLE → DONE on accept of a single-cycle op.
  - IDLE → COUNT on accept of an M op whose latency L > 1.
  - COUNT → DONE when cnt reaches L−1.
  - DONE → DONE on accept, or IDLE on out_ready without a new accept.
  - DONE + accept of an M op with L > 1 → COUNT.
- Latency L: 1 for single-cycle ops, MUL_CYCLES for func3 0–3, DIV_CYCLES for func3 4–7.
- An M op with L = 1 behaves as single-cycle, but multicycle still reads 1.
- busy=1 only in COUNT. cnt is 6 bits, cleared on accept, increments in COUNT, never wraps.
- sel, multicycle and illegal are registered on accept and held stable until the next accept.
- flush: next state IDLE, out_valid=0, cnt=0. sel is unchanged. Flush beats a simultaneous accept and a simultaneous out_ready.
- Reset (async): state IDLE, sel=0, out_valid=0, busy=0, multicycle=0, illegal=0, cnt=0. in_ready reads 1 after reset release.

## Timing
- Single-cycle op: accepted at edge N, out_valid=1 after edge N.
- M op with latency L: out_valid=1 after edge N+L−1. busy is high for L−1 cycles.
- Back-to-back single-cycle ops with out_ready=1 sustain 1 op/cycle.
- out_valid is held with sel stable until out_ready. No combinational path from in_valid to out_valid.
- in_ready depends combinationally only on state and out_ready.

## Structure
- Package alu_pkg holds the sel code localparams, the alu_op constants (ALU_ADD, ALU_SUB, ALU_R, ALU_I) and the FSM state enum.
- Sub-module alu_sel_decode is purely combinational: (alu_op, func3, func7, ENABLE_M) → (sel, is_m, lat_sel, illegal).
- The top level holds the FSM, counter and output registers.

## Test plan
- Reset with async rst asserted mid-cycle → all outputs 0, in_ready=1. Then accept alu_op=2, func3=0, func7=0x20 → sel=00110, out_valid=1 one cycle later.
- Sweep every alu_op/func3/func7 ∈ {0x00, 0x20, 0x01, 0x7F} with ENABLE_M=0 and 1 → sel and illegal match the table, e.g. I-type func3=1, func7=0x20 → illegal=1, sel=00010.
- DIV (func3=4, func7=0x01), DIV_CYCLES=33, out_ready=1 → busy high for 32 cycles, in_ready=0 throughout, out_valid on cycle 33, sel=10100 stable across all 33 cycles.
- Stream 4 single-cycle ops with out_ready toggling 1,0,1,1 → no op lost or duplicated, in_ready low exactly when out_valid=1 and out_ready=0.
- flush at cycle 5 of a MUL with MUL_CYCLES=8 → IDLE next cycle, out_valid never rises. A new ADD presented together with flush is not accepted; on re-presentation it completes in 1 cycle.
